// File: rtl/riscv_np_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package riscv_np_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: slots are allocated at grant time and filled by responses in order.
module fetch_queue
    import riscv_np_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_flush,
    input  logic          i_alloc,
    input  logic [31:0]   i_alloc_pc,
    input  logic          i_fill,
    input  logic [31:0]   i_fill_data,
    input  logic          i_pop,
    output fq_entry_t     o_head,
    output logic [AW:0]   o_count
);

    fq_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_fptr;
    logic [AW:0]   r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_fptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_fptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
        end else begin
            if (i_alloc) begin
                r_mem[r_tail] <= '{pc: i_alloc_pc, insn: NOP_INSN, filled: 1'b0};
                r_tail        <= r_tail + 1'b1;
            end
            // The fill pointer always trails the tail, so it never hits the slot being allocated.
            if (i_fill) begin
                r_mem[r_fptr].insn   <= i_fill_data;
                r_mem[r_fptr].filled <= 1'b1;
                r_fptr               <= r_fptr + 1'b1;
            end
            if (i_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_alloc} - {{AW{1'b0}}, i_pop};
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, imem request/response handling, redirect flush.
// Optional FETCH_PERF_EN adds fetch/bubble/flush performance counters.
module fetch_stage
    import riscv_np_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic         CLK,
    input  logic         RST,
    output logic         IMEM_REQ,
    output logic [31:0]  IMEM_ADDR,
    input  logic         IMEM_GNT,
    input  logic         IMEM_RVALID,
    input  logic [31:0]  IMEM_RDATA,
    input  logic         STALL_IF,
    input  logic         REDIRECT,
    input  logic [31:0]  REDIRECT_PC,
    output logic [31:0]  PC_IF,
    output logic [31:0]  IDATA_IF,
    output logic [31:0]  PC4_IF,
    output logic         VALID_IF,
    output fetch_state_t DBG_STATE
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  PERF_FETCH_CNT,
    output logic [31:0]  PERF_BUBBLE_CNT,
    output logic [31:0]  PERF_FLUSH_CNT
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;
    // Stale responses can accumulate across back-to-back redirects, so drop gets extra headroom.
    localparam int DW = 8;

    fetch_state_t r_state;
    logic [31:0]  r_fpc;
    logic [CW-1:0] r_outstanding;
    logic [DW-1:0] r_drop;
    logic [31:0]  r_pc_hold;

    fq_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_occ;
    logic          w_valid;
    logic          w_pop;
    logic          w_grant;
    logic          w_fill;
    logic          w_drop_rsp;
    logic [DW-1:0] w_inflight;
    logic [DW-1:0] w_drop_redir;
    logic          w_unused;

    assign w_unused = ^REDIRECT_PC[1:0];

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .CLK         (CLK),
        .RST         (RST),
        .i_flush     (REDIRECT),
        .i_alloc     (w_grant),
        .i_alloc_pc  (r_fpc),
        .i_fill      (w_fill),
        .i_fill_data (IMEM_RDATA),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Outstanding requests already own a queue slot, so occupancy is the slot count less this cycle's pop.
    always_comb begin
        w_valid      = w_head.filled && (w_count != '0);
        w_pop        = w_valid && !STALL_IF && !REDIRECT;
        w_occ        = w_count - {{(CW-1){1'b0}}, w_pop};
        IMEM_REQ     = (r_state != ST_BOOT) && !REDIRECT && (w_occ < CW'(QDEPTH));
        IMEM_ADDR    = r_fpc;
        w_grant      = IMEM_REQ && IMEM_GNT;
        w_fill       = (r_state == ST_RUN) && IMEM_RVALID && !REDIRECT && (r_outstanding != '0);
        w_drop_rsp   = (r_state == ST_FLUSH) && IMEM_RVALID && !REDIRECT;
        w_inflight   = r_drop + DW'(r_outstanding);
        w_drop_redir = w_inflight - DW'(IMEM_RVALID && (w_inflight != '0));
        VALID_IF     = w_valid;
        PC_IF        = w_valid ? w_head.pc : r_pc_hold;
        IDATA_IF     = w_valid ? w_head.insn : NOP_INSN;
        PC4_IF       = PC_IF + 32'd4;
        DBG_STATE    = r_state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= ST_BOOT;
            r_fpc         <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_pc_hold     <= '0;
        end else begin
            r_pc_hold <= PC_IF;
            if (REDIRECT) begin
                r_fpc         <= {REDIRECT_PC[31:2], 2'b00};
                r_outstanding <= '0;
                r_drop        <= w_drop_redir;
                r_state       <= (w_drop_redir != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                if (w_grant) r_fpc <= r_fpc + 32'd4;
                r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_fill);
                case (r_state)
                    ST_BOOT:  r_state <= ST_RUN;
                    ST_RUN:   r_state <= ST_RUN;
                    ST_FLUSH: begin
                        if (w_drop_rsp) begin
                            r_drop <= r_drop - 1'b1;
                            if (r_drop == DW'(1)) r_state <= ST_RUN;
                        end
                    end
                    default:  r_state <= ST_BOOT;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && r_state == ST_RUN && IMEM_RVALID && !REDIRECT)
            assert (r_outstanding != '0)
            else $error("fetch_stage: imem response with no slot awaiting fill");
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PERF_FETCH_CNT  <= '0;
            PERF_BUBBLE_CNT <= '0;
            PERF_FLUSH_CNT  <= '0;
        end else begin
            if (w_pop) PERF_FETCH_CNT <= PERF_FETCH_CNT + 32'd1;
            if (!w_valid && r_state != ST_BOOT) PERF_BUBBLE_CNT <= PERF_BUBBLE_CNT + 32'd1;
            if (REDIRECT) PERF_FLUSH_CNT <= PERF_FLUSH_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model and an expected-PC scoreboard.
module tb_fetch_stage;
    import riscv_np_pkg::*;

    logic         CLK;
    logic         RST;
    logic         IMEM_REQ;
    logic [31:0]  IMEM_ADDR;
    logic         IMEM_GNT;
    logic         IMEM_RVALID;
    logic [31:0]  IMEM_RDATA;
    logic         STALL_IF;
    logic         REDIRECT;
    logic [31:0]  REDIRECT_PC;
    logic [31:0]  PC_IF;
    logic [31:0]  IDATA_IF;
    logic [31:0]  PC4_IF;
    logic         VALID_IF;
    fetch_state_t DBG_STATE;
`ifdef FETCH_PERF_EN
    logic [31:0]  PERF_FETCH_CNT;
    logic [31:0]  PERF_BUBBLE_CNT;
    logic [31:0]  PERF_FLUSH_CNT;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    int          deny_left = 0;
    logic [31:0] deny_addr = 32'h0000_0010;
    bit          rsp_hold  = 1'b0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .STALL_IF    (STALL_IF),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .PC_IF       (PC_IF),
        .IDATA_IF    (IDATA_IF),
        .PC4_IF      (PC4_IF),
        .VALID_IF    (VALID_IF),
        .DBG_STATE   (DBG_STATE)
`ifdef FETCH_PERF_EN
        ,
        .PERF_FETCH_CNT  (PERF_FETCH_CNT),
        .PERF_BUBBLE_CNT (PERF_BUBBLE_CNT),
        .PERF_FLUSH_CNT  (PERF_FLUSH_CNT)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'h5A00_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req",   32'(IMEM_REQ),  32'd0);
        check("rst_addr",  IMEM_ADDR,      32'h0000_0000);
        check("rst_pc",    PC_IF,          32'd0);
        check("rst_idata", IDATA_IF,       32'h0000_0013);
        check("rst_pc4",   PC4_IF,         32'd4);
        check("rst_valid", 32'(VALID_IF),  32'd0);
        check("rst_state", 32'(DBG_STATE), 32'(ST_BOOT));
    endtask

    // ---------------- memory model: in-order, response one cycle after grant ----------------
    initial begin
        bit          g;
        bit          v;
        logic [31:0] g_addr;
        g = 1'b0; v = 1'b0; g_addr = '0;
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                mem_q.delete();
                g = 1'b0;
                v = 1'b0;
            end else begin
                if (v && mem_q.size() > 0) void'(mem_q.pop_front());
                if (g) mem_q.push_back(g_addr);
                v = !rsp_hold && (mem_q.size() > 0);
            end
            IMEM_RVALID = v;
            IMEM_RDATA  = v ? insn_of(mem_q[0]) : 32'd0;
            if (IMEM_REQ && IMEM_ADDR == deny_addr && deny_left > 0) begin
                IMEM_GNT = 1'b0;
                deny_left--;
            end else begin
                IMEM_GNT = 1'b1;
            end
            g      = !RST && IMEM_REQ && IMEM_GNT;
            g_addr = IMEM_ADDR;
        end
    end

    // ---------------- monitor: every consumed instruction pops the scoreboard ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge CLK);
            #3;
            if (!RST && VALID_IF && !STALL_IF && !REDIRECT) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_insn: pc %h presented, none expected", PC_IF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc",    PC_IF,    e);
                    check("sb_idata", IDATA_IF, insn_of(e));
                    check("sb_pc4",   PC4_IF,   e + 32'd4);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pc(input logic [31:0] pc);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(VALID_IF && PC_IF == pc) && n < 80);
        n_checks++;
        if (!(VALID_IF && PC_IF == pc)) begin
            n_fail++;
            $display("FAIL wait_pc: pc %h never presented, last %h", pc, PC_IF);
        end
    endtask

    task automatic wait_full();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(!VALID_IF && !IMEM_REQ) && n < 40);
        n_checks++;
        if (VALID_IF || IMEM_REQ) begin
            n_fail++;
            $display("FAIL wait_full: valid %b req %b", VALID_IF, IMEM_REQ);
        end
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST = 1'b0;
        #2;
        check("boot_state", 32'(DBG_STATE), 32'(ST_BOOT));
        check("boot_req",   32'(IMEM_REQ),  32'd0);
        @(negedge CLK);
        #2;
        check("run_state",  32'(DBG_STATE), 32'(ST_RUN));
        check("run_req",    32'(IMEM_REQ),  32'd1);
        check("run_addr",   IMEM_ADDR,      32'h0000_0000);
        @(negedge CLK);
        #2;
        check("lat_valid1", 32'(VALID_IF),  32'd0);
        @(negedge CLK);
        #2;
        check("lat_valid2", 32'(VALID_IF),  32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        RST = 1'b1; STALL_IF = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
        repeat (2) @(negedge CLK);
        #2;
        check_reset_outputs();

        // zero-wait stream, then stall on PC 8, then grant delay on 0x10
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        deny_addr = 32'h0000_0010;
        deny_left = 4;
        release_reset();
        wait_pc(32'h8);
        STALL_IF = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge CLK);
            #2;
            check("stall_pc",    PC_IF,         32'h8);
            check("stall_idata", IDATA_IF,      insn_of(32'h8));
            check("stall_pc4",   PC4_IF,        32'hC);
            check("stall_req",   32'(IMEM_REQ), 32'd0);
        end
        nb = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (k == 0) STALL_IF = 1'b0;
            #2;
            check("gnt_wait_req",  32'(IMEM_REQ), 32'd1);
            check("gnt_wait_addr", IMEM_ADDR,     32'h10);
            if (!VALID_IF) begin
                nb++;
                check("bubble_idata", IDATA_IF, NOP_INSN);
                check("bubble_pc",    PC_IF,    32'hC);
            end
        end
        check("bubble_count", 32'(nb), 32'd2);

        // fill the queue with two unanswered requests, then redirect
        wait_pc(32'h18);
        rsp_hold = 1'b1;
        wait_full();
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        #2;
        check("redir_req", 32'(IMEM_REQ), 32'd0);
        @(negedge CLK);
        REDIRECT = 1'b0;
        rsp_hold = 1'b0;
        #2;
        check("redir_addr",   IMEM_ADDR,      32'h100);
        check("redir_state1", 32'(DBG_STATE), 32'(ST_FLUSH));
        check("redir_valid",  32'(VALID_IF),  32'd0);
        @(negedge CLK);
        #2;
        check("redir_state2", 32'(DBG_STATE), 32'(ST_FLUSH));
        @(negedge CLK);
        #2;
        check("redir_state3", 32'(DBG_STATE), 32'(ST_RUN));

        // redirect with a simultaneous response while stalled
        wait_pc(32'h108);
        STALL_IF    = 1'b1;
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0200;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        #2;
        check("r2_rvalid", 32'(IMEM_RVALID), 32'd1);
        check("r2_req",    32'(IMEM_REQ),    32'd0);
        @(negedge CLK);
        STALL_IF = 1'b0;
        REDIRECT = 1'b0;
        #2;
        check("r2_valid", 32'(VALID_IF),  32'd0);
        check("r2_state", 32'(DBG_STATE), 32'(ST_RUN));
        check("r2_addr",  IMEM_ADDR,      32'h200);
        check("r2_req2",  32'(IMEM_REQ),  32'd1);

        // asynchronous reset with a response in flight
        wait_pc(32'h210);
        RST = 1'b1;
        #2;
        check_reset_outputs();
        check("pre_rst_drain", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        @(negedge CLK);
        release_reset();
        wait_pc(32'h8);
        STALL_IF = 1'b1;
        repeat (3) @(negedge CLK);
        #2;
        check("final_drain", 32'(exp_q.size()), 32'd0);
        check("final_hold",  PC_IF,             32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Sits directly upstream of the IF/ID latch and drives its PC_IF, IDATA_IF and PC4_IF inputs.
- Owns the fetch PC and a request/grant/response interface to instruction memory.
- Buffers in-order responses in a small queue, holds its output under decode stall, and flushes on branch/jump redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
QDEPTH, 2, queue entries; also the maximum number of outstanding memory requests (power of 2, range 2..8)

Ports:
CLK  input  1  clock
RST  input  1  reset
IMEM_REQ  output  1  fetch request
IMEM_ADDR  output  32  word-aligned fetch address
IMEM_GNT  input  1  request accepted this cycle
IMEM_RVALID  input  1  response valid; responses return in order, at least 1 cycle after grant
IMEM_RDATA  input  32  instruction word
STALL_IF  input  1  decode cannot accept; hold the current output
REDIRECT  input  1  taken branch/jump from EX
REDIRECT_PC  input  32  redirect target
PC_IF  output  32  PC of the presented instruction
IDATA_IF  output  32  presented instruction, or NOP when not valid
PC4_IF  output  32  PC_IF+4
VALID_IF  output  1  presented instruction is real

Behaviour:
- Reset: RST asynchronous, active-high; clock CLK.
  - On reset: fpc=RESET_PC, queue empty, outstanding=0, drop=0, state=BOOT.
  - Outputs during reset: IMEM_REQ=0, IMEM_ADDR=RESET_PC, PC_IF=0, IDATA_IF=32'h0000_0013, PC4_IF=4, VALID_IF=0.
- FSM states:
  - BOOT: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - FLUSH: drop>0; discard responses until drop==0, then RUN.
- Request issue:
  - IMEM_REQ=1 in RUN or FLUSH when (queue_count + outstanding) < QDEPTH and REDIRECT=0.
  - IMEM_ADDR=fpc.
  - Request held stable until IMEM_GNT. On grant: fpc+=4 (32-bit wrap, no flag) and a queue slot is allocated with its pc.
- Response:
  - In RUN, IMEM_RVALID fills the oldest allocated unfilled slot with IMEM_RDATA.
  - In FLUSH, each IMEM_RVALID decrements drop and is discarded.
- Output presentation:
  - Combinational from the queue head.
  - VALID_IF=1 iff the head is filled; then PC_IF=head.pc and IDATA_IF=head.insn.
  - Otherwise VALID_IF=0, IDATA_IF=NOP, and PC_IF holds its last value.
  - PC4_IF=PC_IF+4 always.
  - Head is popped on a cycle with VALID_IF=1 and STALL_IF=0. Head is never popped while STALL_IF=1, so the output is unchanged.
- Redirect (highest priority):
  - fpc<={REDIRECT_PC[31:2],2'b00} and the whole queue is flushed.
  - drop<=drop+outstanding-(RVALID this cycle).
  - Any RVALID in the same cycle is discarded.
  - Next state FLUSH if the resulting drop>0, else RUN.
  - A redirect during FLUSH reloads fpc and accumulates drop.
  - A redirect overrides STALL_IF and any simultaneous grant (IMEM_REQ is forced 0 that cycle, so no grant is counted).
- Throughput: with zero-wait memory and no stall, one instruction per cycle after a 2-cycle first-fetch latency.
- Full queue: no request. Empty queue: VALID_IF=0 bubble (NOP).
- RVALID with no slot awaiting fill in RUN: assertion error; the response is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds output ports:
  - PERF_FETCH_CNT (32): count of popped instructions.
  - PERF_BUBBLE_CNT (32): cycles with VALID_IF=0 and not in BOOT.
  - PERF_FLUSH_CNT (32): count of REDIRECT cycles.
- All three are reset to 0 and wrap on overflow.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_np_pkg holds:
  - NOP_INSN=32'h0000_0013
  - DEFAULT_RESET_PC
  - fetch FSM state encoding (BOOT/RUN/FLUSH)
  - the queue-entry typedef {pc[31:0], insn[31:0], filled}
- One sub-module: fetch_queue. It is a circular buffer with alloc/fill/pop/flush controls and head/count outputs.
- Top level keeps the FSM, fpc, outstanding and drop counters.

Test Plan:
- Zero-wait memory (GNT=1, RVALID the next cycle), RESET_PC=0 → VALID_IF from cycle 2 with PC_IF=0,4,8,… one per cycle; PC4_IF=PC_IF+4.
- STALL_IF=1 for 3 cycles while PC_IF=8 → PC_IF/IDATA_IF held at 8 for 3 cycles; IMEM_REQ drops once queue+outstanding=2; resumes at 12 after release.
- GNT delayed 4 cycles on address 0x10 → IMEM_ADDR held at 0x10 with IMEM_REQ=1 throughout; VALID_IF=0 bubbles with IDATA_IF=0x00000013.
- REDIRECT to 0x103 with 2 requests outstanding → next IMEM_ADDR=0x100; the next 2 RVALIDs are discarded; first VALID_IF shows PC_IF=0x100.
- REDIRECT and RVALID in the same cycle, with STALL_IF=1 → stale response discarded, queue empty next cycle, drop=outstanding-1.
- Assert RST mid-fetch with a response pending → all outputs return to reset values immediately; fetch restarts at RESET_PC after BOOT.
